// File: rtl/multiplier_control.sv
// Sequencer for the 8-bit signed shift-add multiplier datapath (X/A/B, 9-bit adder).
// One multiply per Run press: clear X/A, then N add-or-skip/shift pairs, subtracting on the sign bit.
module multiplier_control #(
  parameter  int N_BITS = 8,
  localparam int CNT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             B0,
  output logic             clear_A_load_B_sig,
  output logic             clr_xa,
  output logic             add_sig,
  output logic             sub_sig,
  output logic             shift_sig,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {IDLE, CLR, OP, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             last_iter;

  assign last_iter = (iter_q == CNT_W'(N_BITS - 1));
  assign iter      = iter_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    iter_d             = iter_q;
    clear_A_load_B_sig = 1'b0;
    clr_xa             = 1'b0;
    add_sig            = 1'b0;
    sub_sig            = 1'b0;
    shift_sig          = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by Reset so every output is quiet while reset is held.
        clear_A_load_B_sig = ClearA_LoadB & ~Reset;
        if (!ClearA_LoadB && Run) begin
          state_d = CLR;
          iter_d  = '0;
        end
      end
      CLR: begin
        clr_xa  = 1'b1;
        busy    = 1'b1;
        state_d = OP;
      end
      OP: begin
        busy    = 1'b1;
        add_sig = B0 & ~last_iter;
        sub_sig = B0 & last_iter;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_sig = 1'b1;
        busy      = 1'b1;
        if (last_iter) begin
          state_d = HOLD;
        end else begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = OP;
        end
      end
      HOLD: begin
        // Wait for Run release so a held button yields exactly one multiply.
        done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control: a behavioural X/A/B datapath driven by the strobes,
// with a scoreboard of hand-computed products checked whenever done rises.
module tb_multiplier_control;

  logic       clk = 1'b0;
  logic       Reset, Run, ClearA_LoadB, B0;
  logic       clear_A_load_B_sig, clr_xa, add_sig, sub_sig, shift_sig, busy, done;
  logic [2:0] iter;

  logic [7:0] sw = 8'h00;
  logic       dp_x = 1'b0;
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;

  typedef struct {
    logic [15:0] ab;
    logic        x;
    int          adds;
    int          subs;
  } exp_t;
  exp_t q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, clr_cyc = 0, clr_total = 0, strobe_total = 0, viol = 0;
  int adds = 0, subs = 0, shifts = 0;
  logic done_q = 1'b0;

  multiplier_control #(.N_BITS(8)) dut (
    .clk(clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .B0(B0),
    .clear_A_load_B_sig(clear_A_load_B_sig), .clr_xa(clr_xa), .add_sig(add_sig),
    .sub_sig(sub_sig), .shift_sig(shift_sig), .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  assign B0 = dp_b[0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clear_A_load_B_sig) begin
      dp_x <= 1'b0; dp_a <= 8'h00; dp_b <= sw;
    end else if (clr_xa) begin
      dp_x <= 1'b0; dp_a <= 8'h00;
    end else if (add_sig) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} + {sw[7], sw};
    end else if (sub_sig) begin
      {dp_x, dp_a} <= {dp_a[7], dp_a} - {sw[7], sw};
    end else if (shift_sig) begin
      dp_a <= {dp_x, dp_a[7:1]};
      dp_b <= {dp_a[0], dp_b[7:1]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: strobe accounting, invariants, and scoreboard pop on done rising.
  always @(negedge clk) begin
    exp_t e;
    if (!Reset) begin
      if ($countones({clear_A_load_B_sig, clr_xa, add_sig, sub_sig, shift_sig}) > 1) viol++;
      if (sub_sig && iter != 3'd7) viol++;
      if (clr_xa) begin
        adds = 0; subs = 0; shifts = 0; clr_cyc = cyc; clr_total++;
      end
      if (clear_A_load_B_sig | clr_xa | add_sig | sub_sig | shift_sig) strobe_total++;
      if (add_sig) adds++;
      if (sub_sig) subs++;
      if (shift_sig) shifts++;
      if (done && !done_q) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("product_ab", {16'h0, dp_a, dp_b}, {16'h0, e.ab});
          check("product_x", {31'h0, dp_x}, {31'h0, e.x});
          check("add_count", adds, e.adds);
          check("sub_count", subs, e.subs);
          check("shift_count", shifts, 8);
          check("latency_clr_to_hold", cyc - clr_cyc, 17);
        end
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_b(input logic [7:0] b);
    sw = b; ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
  endtask

  task automatic multiply(input logic [7:0] s, input logic [15:0] ab, input logic x,
                          input int na, input int ns);
    exp_t e;
    e.ab = ab; e.x = x; e.adds = na; e.subs = ns;
    sw = s; q.push_back(e);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    wait_done(40);
    tick();
    @(negedge clk);
    check("hold_one_cycle_done", {31'h0, done}, 32'd0);
    check("idle_after_hold_busy", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    logic found;
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_strobes", {27'h0, clear_A_load_B_sig, clr_xa, add_sig, sub_sig, shift_sig}, 32'd0);
    check("reset_busy_done", {30'h0, busy, done}, 32'd0);
    check("reset_iter", {29'h0, iter}, 32'd0);
    Reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("idle_after_release", {29'h0, busy, done, clr_xa}, 32'd0);

    load_b(8'h03); multiply(8'h07, 16'h0015, 1'b0, 2, 0);
    load_b(8'hFF); multiply(8'hFF, 16'h0001, 1'b0, 7, 1);
    load_b(8'h03); multiply(8'hFB, 16'hFFF1, 1'b1, 2, 0);
    load_b(8'h80); multiply(8'h05, 16'hFD80, 1'b1, 0, 1);

    // Run held high: exactly one multiply, done persists.
    load_b(8'h03);
    begin
      exp_t e;
      e.ab = 16'h0015; e.x = 1'b0; e.adds = 2; e.subs = 0;
      q.push_back(e);
    end
    base = clr_total;
    sw = 8'h07; Run = 1'b1;
    repeat (40) tick();
    @(negedge clk);
    check("held_run_done", {31'h0, done}, 32'd1);
    check("held_run_single_clr", clr_total - base, 32'd1);
    Run = 1'b0;
    tick();
    @(negedge clk);
    check("release_to_idle", {31'h0, done}, 32'd0);
    begin
      exp_t e;
      e.ab = 16'h0093; e.x = 1'b0; e.adds = 3; e.subs = 0;
      q.push_back(e);
    end
    Run = 1'b1;
    tick();
    @(negedge clk);
    check("repress_clr", {31'h0, clr_xa}, 32'd1);
    Run = 1'b0;
    wait_done(40);
    tick(); tick();

    // Reset mid-run in OP of iteration 3.
    load_b(8'h55);
    sw = 8'h03; Run = 1'b1;
    tick();
    Run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy && iter == 3'd3 && !shift_sig && !clr_xa) found = 1'b1;
    end
    check("found_op_iter3", {31'h0, found}, 32'd1);
    Reset = 1'b1;
    tick();
    @(negedge clk);
    check("abort_strobes", {27'h0, clear_A_load_B_sig, clr_xa, add_sig, sub_sig, shift_sig}, 32'd0);
    check("abort_busy_done_iter", {27'h0, busy, done, iter}, 32'd0);
    tick();
    Reset = 1'b0;
    base = strobe_total;
    repeat (5) tick();
    @(negedge clk);
    check("abort_no_strobes", strobe_total - base, 32'd0);

    // ClearA_LoadB has priority over Run in IDLE.
    base = clr_total;
    sw = 8'h03; ClearA_LoadB = 1'b1; Run = 1'b1;
    @(negedge clk);
    check("both_high_load", {31'h0, clear_A_load_B_sig}, 32'd1);
    tick();
    @(negedge clk);
    check("both_high_no_clr", {30'h0, clr_xa, busy}, 32'd0);
    check("both_high_no_clr_count", clr_total - base, 32'd0);
    ClearA_LoadB = 1'b0; Run = 1'b0;
    tick();

    check("invariant_violations", viol, 32'd0);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
